// File: rtl/pong_rect_filler.sv
// Rectangle painter for the pong framebuffer: clips one rectangle command to the
// screen and issues one acknowledged 16-bit bridge write per pixel in raster order.
module pong_rect_filler #(
  parameter int          H_RES   = 320,
  parameter int          V_RES   = 240,
  parameter logic [26:0] FB_BASE = 27'h0,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cmd_start,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [11:0] cmd_color,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_error,
  output logic [26:0] bridge_memory_address,
  output logic [1:0]  bridge_memory_byte_enable,
  output logic        bridge_memory_read,
  output logic        bridge_memory_write,
  output logic [15:0] bridge_memory_write_data,
  input  logic        bridge_memory_acknowledge,
  input  logic [15:0] bridge_memory_read_data
);

  localparam logic [9:0]  H_LIM      = 10'(H_RES);
  localparam logic [8:0]  V_LIM      = 9'(V_RES);
  localparam logic [26:0] ROW_STRIDE = 27'(H_RES * 2);
  localparam logic [9:0]  CNT_LAST   = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, GAP, DONE, ERR} state_e;

  state_e      state_q, state_d;
  logic [8:0]  x_q;
  logic [7:0]  y_q;
  logic [8:0]  w_q;
  logic [7:0]  h_q;
  logic [11:0] color_q;
  logic [8:0]  col_q;
  logic [7:0]  row_q;
  logic [9:0]  x_end_q;
  logic [8:0]  y_end_q;
  logic [26:0] addr_q;
  logic [26:0] row_addr_q;
  logic [9:0]  cnt_q;

  logic [9:0]  x_sum;
  logic [8:0]  y_sum;
  logic [9:0]  x_clip;
  logic [8:0]  y_clip;
  logic        empty;
  logic [31:0] first_pix;
  logic [26:0] first_addr;
  logic [9:0]  col_inc;
  logic [8:0]  row_inc;
  logic        last_col;
  logic        last_pix;
  logic        timeout_hit;
  logic        unused_rd;

  assign unused_rd = ^bridge_memory_read_data;

  assign x_sum       = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum       = {1'b0, y_q} + {1'b0, h_q};
  assign x_clip      = (x_sum > H_LIM) ? H_LIM : x_sum;
  assign y_clip      = (y_sum > V_LIM) ? V_LIM : y_sum;
  assign empty       = (w_q == 9'd0) || (h_q == 8'd0) ||
                       ({1'b0, x_q} >= H_LIM) || ({1'b0, y_q} >= V_LIM);
  assign first_pix   = 32'(y_q) * 32'(H_RES) + 32'(x_q);
  assign first_addr  = FB_BASE + 27'(first_pix << 1);
  assign col_inc     = {1'b0, col_q} + 10'd1;
  assign row_inc     = {1'b0, row_q} + 9'd1;
  assign last_col    = (col_inc == x_end_q);
  assign last_pix    = last_col && (row_inc == y_end_q);
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cmd_start) state_d = SETUP;
      SETUP: state_d = empty ? DONE : WRITE;
      WRITE: begin
        if (bridge_memory_acknowledge) state_d = last_pix ? DONE : GAP;
        else if (timeout_hit)          state_d = ERR;
      end
      GAP:   state_d = WRITE;
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row start address is kept separately so row changes need no multiply.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      addr_q     <= '0;
      row_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      cnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
          end
        end
        SETUP: begin
          col_q      <= x_q;
          row_q      <= y_q;
          x_end_q    <= x_clip;
          y_end_q    <= y_clip;
          addr_q     <= first_addr;
          row_addr_q <= first_addr;
        end
        WRITE: begin
          if (!bridge_memory_acknowledge) cnt_q <= cnt_q + 10'd1;
        end
        GAP: begin
          if (last_col) begin
            col_q      <= x_q;
            row_q      <= row_q + 8'd1;
            row_addr_q <= row_addr_q + ROW_STRIDE;
            addr_q     <= row_addr_q + ROW_STRIDE;
          end else begin
            col_q  <= col_q + 9'd1;
            addr_q <= addr_q + 27'd2;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bridge_memory_write       = (state_q == WRITE);
    bridge_memory_read        = 1'b0;
    bridge_memory_address     = bridge_memory_write ? addr_q : 27'd0;
    bridge_memory_write_data  = bridge_memory_write ? {4'h0, color_q} : 16'd0;
    bridge_memory_byte_enable = bridge_memory_write ? 2'b11 : 2'b00;
    cmd_busy                  = (state_q != IDLE);
    cmd_done                  = (state_q == DONE) || (state_q == ERR);
    cmd_error                 = (state_q == ERR);
  end

endmodule

// File: tb/tb_pong_rect_filler.sv
// Directed bench for pong_rect_filler: a reference model queues every expected pixel
// write, and an acknowledging bridge responder pops and compares them as they complete.
module tb_pong_rect_filler;

  logic        clk_clk;
  logic        reset_reset_n;
  logic        cmd_start;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [11:0] cmd_color;
  logic        cmd_busy;
  logic        cmd_done;
  logic        cmd_error;
  logic [26:0] bridge_memory_address;
  logic [1:0]  bridge_memory_byte_enable;
  logic        bridge_memory_read;
  logic        bridge_memory_write;
  logic [15:0] bridge_memory_write_data;
  logic        bridge_memory_acknowledge;
  logic [15:0] bridge_memory_read_data;

  typedef struct {
    logic [26:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t expQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  ackLat = 0;
  bit  ackEnable = 1'b1;
  int  ackCnt = 0;
  int  doneCnt = 0;
  int  writeHighCnt = 0;
  int  waitCnt = 0;

  pong_rect_filler #(.H_RES(320), .V_RES(240), .FB_BASE(27'h0), .TIMEOUT(8)) dut (
    .clk_clk                   (clk_clk),
    .reset_reset_n             (reset_reset_n),
    .cmd_start                 (cmd_start),
    .cmd_x                     (cmd_x),
    .cmd_y                     (cmd_y),
    .cmd_w                     (cmd_w),
    .cmd_h                     (cmd_h),
    .cmd_color                 (cmd_color),
    .cmd_busy                  (cmd_busy),
    .cmd_done                  (cmd_done),
    .cmd_error                 (cmd_error),
    .bridge_memory_address     (bridge_memory_address),
    .bridge_memory_byte_enable (bridge_memory_byte_enable),
    .bridge_memory_read        (bridge_memory_read),
    .bridge_memory_write       (bridge_memory_write),
    .bridge_memory_write_data  (bridge_memory_write_data),
    .bridge_memory_acknowledge (bridge_memory_acknowledge),
    .bridge_memory_read_data   (bridge_memory_read_data)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bridge responder: acknowledges ackLat cycles after write rises and scores each completed write.
  initial begin
    bridge_memory_acknowledge = 1'b0;
    forever begin
      @(negedge clk_clk);
      bridge_memory_acknowledge = 1'b0;
      if (cmd_done === 1'b1) doneCnt++;
      if (bridge_memory_write === 1'b1) begin
        writeHighCnt++;
        if (ackEnable) begin
          if (waitCnt == ackLat) begin
            bridge_memory_acknowledge = 1'b1;
            waitCnt = 0;
            ackCnt++;
            if (expQ.size() == 0) begin
              checkOutput("unexpected_write", {5'd0, bridge_memory_address}, 32'hFFFF_FFFF);
            end else begin
              wr_t e;
              e = expQ.pop_front();
              checkOutput("wr_addr", {5'd0, bridge_memory_address}, {5'd0, e.addr});
              checkOutput("wr_data", {16'd0, bridge_memory_write_data}, {16'd0, e.data});
              checkOutput("wr_be", {30'd0, bridge_memory_byte_enable}, 32'd3);
            end
          end else begin
            waitCnt++;
          end
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1 with the model writes queued.
  task automatic applyStimulus(input int x, input int y, input int w, input int h, input logic [11:0] color);
    int xe;
    int ye;
    xe = (x + w > 320) ? 320 : x + w;
    ye = (y + h > 240) ? 240 : y + h;
    if (w != 0 && h != 0 && x < 320 && y < 240) begin
      for (int r = y; r < ye; r++) begin
        for (int c = x; c < xe; c++) begin
          wr_t e;
          e.addr = 27'((r * 320 + c) * 2);
          e.data = {4'h0, color};
          expQ.push_back(e);
        end
      end
    end
    cmd_x = 9'(x);
    cmd_y = 8'(y);
    cmd_w = 9'(w);
    cmd_h = 8'(h);
    cmd_color = color;
    cmd_start = 1'b1;
    @(posedge clk_clk);
    @(negedge clk_clk);
    cmd_start = 1'b0;
  endtask

  task automatic waitDone(input int startCyc, output int doneCyc);
    int cyc;
    cyc = startCyc;
    while (cmd_done !== 1'b1 && cyc < 300) begin
      @(negedge clk_clk);
      cyc++;
    end
    doneCyc = (cmd_done === 1'b1) ? cyc : -1;
  endtask

  initial begin
    int cyc;
    int base;
    int dbase;
    reset_reset_n = 1'b0;
    cmd_start = 1'b0;
    cmd_x = '0;
    cmd_y = '0;
    cmd_w = '0;
    cmd_h = '0;
    cmd_color = '0;
    bridge_memory_read_data = 16'h0;

    repeat (3) @(negedge clk_clk);
    checkOutput("rst_write", {31'd0, bridge_memory_write}, 32'd0);
    checkOutput("rst_addr", {5'd0, bridge_memory_address}, 32'd0);
    checkOutput("rst_data", {16'd0, bridge_memory_write_data}, 32'd0);
    checkOutput("rst_be", {30'd0, bridge_memory_byte_enable}, 32'd0);
    checkOutput("rst_read", {31'd0, bridge_memory_read}, 32'd0);
    checkOutput("rst_busy", {31'd0, cmd_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, cmd_done}, 32'd0);
    checkOutput("rst_error", {31'd0, cmd_error}, 32'd0);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);
    checkOutput("idle_writes", writeHighCnt, 0);
    checkOutput("idle_dones", doneCnt, 0);
    checkOutput("idle_busy", {31'd0, cmd_busy}, 32'd0);

    // 3x2 rectangle, immediate acknowledge
    ackLat = 0;
    base = ackCnt;
    applyStimulus(10, 5, 3, 2, 12'hF00);
    checkOutput("t1_busy_c1", {31'd0, cmd_busy}, 32'd1);
    waitDone(1, cyc);
    checkOutput("t1_done_cycle", cyc, 13);
    checkOutput("t1_error", {31'd0, cmd_error}, 32'd0);
    checkOutput("t1_busy_done", {31'd0, cmd_busy}, 32'd1);
    @(negedge clk_clk);
    checkOutput("t1_busy_after", {31'd0, cmd_busy}, 32'd0);
    checkOutput("t1_acks", ackCnt - base, 6);
    checkOutput("t1_left", expQ.size(), 0);

    // Corner rectangle clipped to 2 pixels, latency 2
    ackLat = 2;
    base = ackCnt;
    applyStimulus(318, 239, 5, 4, 12'h0AB);
    waitDone(1, cyc);
    checkOutput("t2_done_cycle", cyc, 9);
    checkOutput("t2_error", {31'd0, cmd_error}, 32'd0);
    @(negedge clk_clk);
    checkOutput("t2_acks", ackCnt - base, 2);
    checkOutput("t2_left", expQ.size(), 0);

    // Empty commands: zero width and off-screen column
    base = ackCnt;
    applyStimulus(50, 50, 0, 10, 12'h111);
    waitDone(1, cyc);
    checkOutput("t3_w0_done_cycle", cyc, 2);
    @(negedge clk_clk);
    applyStimulus(320, 10, 4, 4, 12'h222);
    waitDone(1, cyc);
    checkOutput("t3_x_off_done_cycle", cyc, 2);
    @(negedge clk_clk);
    checkOutput("t3_acks", ackCnt - base, 0);

    // Start strobe while busy must be ignored
    base = ackCnt;
    dbase = doneCnt;
    applyStimulus(0, 0, 1, 1, 12'h123);
    @(negedge clk_clk);
    cmd_x = 9'd100;
    cmd_y = 8'd100;
    cmd_w = 9'd5;
    cmd_h = 8'd5;
    cmd_color = 12'hABC;
    cmd_start = 1'b1;
    @(negedge clk_clk);
    cmd_start = 1'b0;
    waitDone(3, cyc);
    checkOutput("t4_done_cycle", cyc, 5);
    repeat (10) @(negedge clk_clk);
    checkOutput("t4_done_count", doneCnt - dbase, 1);
    checkOutput("t4_acks", ackCnt - base, 1);
    checkOutput("t4_left", expQ.size(), 0);

    // No acknowledge: timeout after 8 held cycles
    ackEnable = 1'b0;
    base = writeHighCnt;
    applyStimulus(20, 20, 2, 2, 12'hFFF);
    waitDone(1, cyc);
    checkOutput("t5_done_cycle", cyc, 10);
    checkOutput("t5_error", {31'd0, cmd_error}, 32'd1);
    checkOutput("t5_write_in_err", {31'd0, bridge_memory_write}, 32'd0);
    @(negedge clk_clk);
    checkOutput("t5_write_cycles", writeHighCnt - base, 8);
    checkOutput("t5_busy_after", {31'd0, cmd_busy}, 32'd0);
    checkOutput("t5_error_after", {31'd0, cmd_error}, 32'd0);
    expQ.delete();

    // Reset while a write is held
    applyStimulus(40, 40, 4, 1, 12'h055);
    repeat (2) @(negedge clk_clk);
    checkOutput("t6_write_held", {31'd0, bridge_memory_write}, 32'd1);
    dbase = doneCnt;
    reset_reset_n = 1'b0;
    #1;
    checkOutput("t6_write_async", {31'd0, bridge_memory_write}, 32'd0);
    checkOutput("t6_busy_async", {31'd0, cmd_busy}, 32'd0);
    expQ.delete();
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    checkOutput("t6_no_done", doneCnt - dbase, 0);

    ackEnable = 1'b1;
    ackLat = 1;
    base = ackCnt;
    applyStimulus(0, 1, 2, 1, 12'h0F0);
    waitDone(1, cyc);
    checkOutput("t6_fresh_done_cycle", cyc, 7);
    checkOutput("t6_fresh_error", {31'd0, cmd_error}, 32'd0);
    @(negedge clk_clk);
    checkOutput("t6_fresh_acks", ackCnt - base, 2);
    checkOutput("t6_fresh_left", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
